// File: rtl/gray_code_converter_pipe.sv
// Two-stage valid/ready Gray<->binary converter with per-word direction select.
// Optional Gray step checker (step_err output) is built when GRAY_STEP_CHECK_EN is defined.
module gray_code_converter_pipe #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_mode,
    output logic [WIDTH-1:0] out_data
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic             step_err
`endif
);

    localparam int STAGES = 2;

    typedef struct packed {
        logic             mode;
        logic [WIDTH-1:0] data;
    } stage_t;

    // Reorder so that the MSB always sits at index WIDTH-1; reversal is its own inverse.
    function automatic logic [WIDTH-1:0] to_canon(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = v;
        if (!MSB_FIRST)
            for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] conv(input logic mode, input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] c, r;
        c = to_canon(v);
        r = '0;
        if (mode) begin
            r = c ^ (c >> 1);
        end else begin
            r[WIDTH-1] = c[WIDTH-1];
            for (int i = WIDTH-2; i >= 0; i--) r[i] = r[i+1] ^ c[i];
        end
        return to_canon(r);
    endfunction

    logic [STAGES:1] vld_pipe;
    stage_t          s1, s2;
    logic            adv1, adv2;

    assign adv2     = !vld_pipe[2] || out_ready;
    assign adv1     = !vld_pipe[1] || adv2;
    assign in_ready = adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1       <= '0;
            s2       <= '0;
        end else begin
            if (adv2) begin
                vld_pipe[2] <= vld_pipe[1];
                s2.mode     <= s1.mode;
                s2.data     <= conv(s1.mode, s1.data);
            end
            if (adv1) begin
                vld_pipe[1] <= in_valid;
                s1.mode     <= in_mode;
                s1.data     <= in_data;
            end
        end
    end

    assign out_valid = vld_pipe[2];
    assign out_mode  = s2.mode;
    assign out_data  = s2.data;

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] prev_gray;
    logic             seen;
    logic             in_err, s1_err, s2_err;

    // Identical words also flag: a legal Gray step flips exactly one bit.
    assign in_err = !in_mode && seen && ($countones(in_data ^ prev_gray) != 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_gray <= '0;
            seen      <= 1'b0;
            s1_err    <= 1'b0;
            s2_err    <= 1'b0;
        end else begin
            if (in_valid && adv1 && !in_mode) begin
                prev_gray <= in_data;
                seen      <= 1'b1;
            end
            if (adv2) s2_err <= s1_err;
            if (adv1) s1_err <= in_err;
        end
    end

    assign step_err = s2_err;
`endif

endmodule
